hub75_la_capture: RTL and testbench
===================================

# hub75_la_capture

Parametrised on-chip logic-analyzer capture core, the successor to the vendor debug probe on the HUB75 panel signals. It samples a WIDTH-bit probe bus into a circular buffer of DEPTH entries, with programmable pre-trigger depth, a per-bit level/edge trigger and a sample-rate divider. After the capture window closes, the buffer can be read back through a trigger-relative address port by a soft register bank or UART dumper.

## Interface
- WIDTH, 12, probe bus width. Default order: data_i[11:0] = {CLK_M,R1,R2,A,B,LAT,rst,OE,G1,G2,B1,B2}.
- ADDR_W, 8, buffer address width. DEPTH = 2**ADDR_W.
- DIV_W, 8, sample divider width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  WIDTH  probe samples.
- arm_i  in  1  single-cycle pulse that latches the configuration and starts a capture; restarts one already in progress.
- abort_i  in  1  returns to IDLE; has priority over arm_i.
- trig_mask_i  in  WIDTH  1 = bit takes part in the trigger.
- trig_value_i  in  WIDTH  required bit value.
- trig_edge_i  in  WIDTH  1 = bit must transition to its value; 0 = level match.
- pre_i  in  ADDR_W  number of pre-trigger samples, clamped to DEPTH-1.
- div_i  in  DIV_W  take a sample every div_i+1 clocks.
- rd_addr_i  in  ADDR_W  window index; 0 = oldest sample.
- rd_data_o  out  WIDTH  buffer word, one cycle after rd_addr_i.
- state_o  out  3  0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE.
- done_o  out  1  high while in DONE.

## Operation
- Config latch: on arm_i, mask, value, edge, pre and div are registered. Input changes after that have no effect until the next arm.
- Arm resets the write pointer, sample counter, divider and prev_valid.
- Sample strobe: asserted when the divider equals the latched div, then the divider reloads to 0. While in PRE, WAIT or POST, each strobe writes data_i at wr_ptr and increments wr_ptr mod DEPTH.
- Trigger (evaluated on strobes only). Each masked bit must satisfy its condition; all such bits are ANDed:
  - level bit: cur == value.
  - edge bit: prev != value and cur == value, with prev = previous strobed sample.
  - Edge bits are false while prev_valid = 0, i.e. on the first strobe after arm.
  - mask = 0 triggers on the first strobe evaluated in WAIT.
- IDLE -> PRE on arm, or IDLE -> WAIT on arm when the latched pre = 0.
- PRE -> WAIT when the sample counter reaches pre. Triggers are ignored while in PRE.
- WAIT, on a trigger strobe:
  - start_ptr = wr_ptr - pre (mod DEPTH).
  - post counter = DEPTH-pre-1.
  - Go to POST, or straight to DONE when the counter is 0.
- POST: each strobe writes a sample and decrements the counter. The strobe that writes the final sample enters DONE.
- Window contents: exactly DEPTH samples. pre samples precede the trigger, the trigger sample sits at index pre, and DEPTH-pre-1 samples follow it.
- DONE: holds until arm_i or abort_i. Reads use physical address (start_ptr + rd_addr_i) mod DEPTH.
- abort_i in any state: go to IDLE, buffer untouched.
- arm_i in any state: restart.
- arm_i and abort_i in the same cycle: abort wins.

## Timing
- Reset values: state_o = 0, done_o = 0, rd_data_o = 0, pointers and counters 0, prev_valid = 0.
- The first strobe occurs on the clock edge after the arm edge. Strobes then follow every div+1 clocks.
- State changes take effect on the same edge that writes the deciding sample.
- done_o rises on the edge that writes the last sample.
- Read latency is 1 clock (synchronous RAM). Data is valid only in DONE; reads in other states have no side effects.
- Reset asserted mid-capture: returns to IDLE immediately. RAM contents are unspecified.

## Test plan
- Reset: hold rst = 0 for 3 clocks -> state_o = 0, done_o = 0, rd_data_o = 0. Arm with rst = 0 has no effect.
- Level trigger: ADDR_W = 4, data_i is a ramp +1 per clock, mask = 0xFFF, value = 0x020, pre = 4, div = 0 -> done_o is set and reads return addr0 = 0x01C, addr4 = 0x020, addr15 = 0x02B.
- Edge trigger on LAT (bit 6): mask = 0x040, value = 0x040, edge = 0x040.
  - LAT is already high at arm; no trigger is allowed until LAT falls and rises again.
  - Index pre must hold the rising sample.
- Immediate trigger and PRE ignore:
  - mask = 0, pre = 0 -> addr0 equals the first sample after arm, and DONE follows after DEPTH strobes.
  - A matching value during PRE (pre = 8, match at sample 3) is ignored.
- Divider: div = 2, ramp data -> consecutive window entries differ by 3.
- Abort: abort_i in WAIT -> state_o = 0 next edge. Simultaneous arm_i + abort_i -> IDLE.

Source files
------------

// File: rtl/hub75_la_capture.sv
// hub75_la_capture: logic-analyzer capture core for the HUB75 probe bus.
// A WIDTH-bit probe bus is sampled into a DEPTH-entry circular buffer.
// Capture has a programmable pre-trigger depth, a per-bit level/edge trigger
// and a sample-rate divider. The closed window is read back relative to its
// oldest sample.
module hub75_la_capture #(
   parameter int unsigned WIDTH  = 12,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  data_i,
   input  logic              arm_i,
   input  logic              abort_i,
   input  logic [WIDTH-1:0]  trig_mask_i,
   input  logic [WIDTH-1:0]  trig_value_i,
   input  logic [WIDTH-1:0]  trig_edge_i,
   input  logic [ADDR_W-1:0] pre_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o,
   output logic [2:0]        state_o,
   output logic              done_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   // Configuration captured at arm time
   logic [WIDTH-1:0]    r_mask;
   logic [WIDTH-1:0]    r_value;
   logic [WIDTH-1:0]    r_edge;
   logic [ADDR_W-1:0]   r_pre;
   logic [DIV_W-1:0]    r_div;

   // Capture datapath
   logic [DIV_W-1:0]    r_div_cnt;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]   r_start_ptr;
   logic [WIDTH-1:0]    r_prev;
   logic                r_prev_valid;
   logic                r_done;
   logic [WIDTH-1:0]    r_rd_data;
   logic [WIDTH-1:0]    r_mem [DEPTH];

   logic                w_active;
   logic                w_strobe;
   logic                w_wr_en;
   logic [WIDTH-1:0]    w_level_ok;
   logic [WIDTH-1:0]    w_edge_ok;
   logic [WIDTH-1:0]    w_bit_ok;
   logic                w_trig;
   logic                w_pre_last;
   logic [ADDR_W-1:0]   w_post_init;
   logic [ADDR_W-1:0]   w_rd_phys;

   // Sampling only happens while a capture window is open
   assign w_active   = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
   assign w_strobe   = w_active && (r_div_cnt == r_div);
   assign w_wr_en    = w_strobe && !abort_i && !arm_i;

   // Per-bit trigger terms; edge terms need a valid previous strobed sample
   assign w_level_ok = ~(data_i ^ r_value);
   assign w_edge_ok  = w_level_ok & (r_prev ^ r_value) & {WIDTH{r_prev_valid}};
   assign w_bit_ok   = ~r_mask | (r_edge & w_edge_ok) | (~r_edge & w_level_ok);
   assign w_trig     = &w_bit_ok;

   // pre is ADDR_W bits wide, so it can never exceed DEPTH-1
   assign w_pre_last  = (r_cnt + ADDR_W'(1)) == r_pre;
   assign w_post_init = {ADDR_W{1'b1}} - r_pre;
   assign w_rd_phys   = r_start_ptr + rd_addr_i;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   // Next-state logic; abort outranks arm, arm outranks everything else
   always_comb begin
      w_next_state = r_state;
      if (abort_i) begin
         w_next_state = S_IDLE;
      end else if (arm_i) begin
         w_next_state = (pre_i == '0) ? S_WAIT : S_PRE;
      end else if (w_strobe) begin
         case (r_state)
            S_PRE:   if (w_pre_last) w_next_state = S_WAIT;
            S_WAIT:  if (w_trig) w_next_state = (w_post_init == '0) ? S_DONE : S_POST;
            S_POST:  if (r_cnt == ADDR_W'(1)) w_next_state = S_DONE;
            default: w_next_state = r_state;
         endcase
      end
   end

   // done flag tracks entry into DONE on the same edge as the state change
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_done <= 1'b0;
      else      r_done <= (w_next_state == S_DONE);
   end

   // Config latch, divider, pointers, counters and trigger history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mask       <= '0;
         r_value      <= '0;
         r_edge       <= '0;
         r_pre        <= '0;
         r_div        <= '0;
         r_div_cnt    <= '0;
         r_wr_ptr     <= '0;
         r_cnt        <= '0;
         r_start_ptr  <= '0;
         r_prev       <= '0;
         r_prev_valid <= 1'b0;
      end else if (abort_i) begin
         r_prev_valid <= r_prev_valid;
      end else if (arm_i) begin
         r_mask       <= trig_mask_i;
         r_value      <= trig_value_i;
         r_edge       <= trig_edge_i;
         r_pre        <= pre_i;
         r_div        <= div_i;
         // Preloading the divider to its terminal value puts the first
         // strobe on the edge right after arm.
         r_div_cnt    <= div_i;
         r_wr_ptr     <= '0;
         r_cnt        <= '0;
         r_prev_valid <= 1'b0;
      end else if (w_strobe) begin
         r_div_cnt    <= '0;
         r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
         r_prev       <= data_i;
         r_prev_valid <= 1'b1;
         case (r_state)
            S_PRE: r_cnt <= r_cnt + ADDR_W'(1);
            S_WAIT: begin
               if (w_trig) begin
                  r_start_ptr <= r_wr_ptr - r_pre;
                  r_cnt       <= w_post_init;
               end
            end
            S_POST: r_cnt <= r_cnt - ADDR_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end else if (w_active) begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   // Sample buffer write port
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= data_i;
   end

   // Trigger-relative synchronous read port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rd_data <= '0;
      else      r_rd_data <= r_mem[w_rd_phys];
   end

   assign rd_data_o = r_rd_data;
   assign state_o   = r_state;
   assign done_o    = r_done;

endmodule

// File: tb/tb_hub75_la_capture.sv
// tb_hub75_la_capture: checks hub75_la_capture (ADDR_W = 4) against a
// window-level reference model computed from the list of strobed samples.
module tb_hub75_la_capture;

   localparam int unsigned WIDTH  = 12;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DIV_W  = 8;
   localparam int          DEPTH  = 16;
   localparam int          MAXE   = 1024;

   logic              clk = 1'b0;
   logic              rst;
   logic [WIDTH-1:0]  data_i;
   logic              arm_i;
   logic              abort_i;
   logic [WIDTH-1:0]  trig_mask_i;
   logic [WIDTH-1:0]  trig_value_i;
   logic [WIDTH-1:0]  trig_edge_i;
   logic [ADDR_W-1:0] pre_i;
   logic [DIV_W-1:0]  div_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic [WIDTH-1:0]  rd_data_o;
   logic [2:0]        state_o;
   logic              done_o;

   always #5 clk = ~clk;

   hub75_la_capture #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_i       (data_i),
      .arm_i        (arm_i),
      .abort_i      (abort_i),
      .trig_mask_i  (trig_mask_i),
      .trig_value_i (trig_value_i),
      .trig_edge_i  (trig_edge_i),
      .pre_i        (pre_i),
      .div_i        (div_i),
      .rd_addr_i    (rd_addr_i),
      .rd_data_o    (rd_data_o),
      .state_o      (state_o),
      .done_o       (done_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // pat[j] is the value on data_i at edge j, edge 0 being the arm edge
   logic [WIDTH-1:0] pat [MAXE];
   logic [WIDTH-1:0] rb  [DEPTH];
   logic [WIDTH-1:0] m_mask, m_value, m_edge;
   int               m_pre, m_div;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  exp;
   } rd_vec_t;

   typedef struct {
      bit arm;
      bit abort;
      int pre;
      int exp_state;
   } ab_vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // n-th strobed sample after arm
   function automatic logic [WIDTH-1:0] samp(input int n);
      return pat[1 + n * (m_div + 1)];
   endfunction

   function automatic bit trig_at(input int n);
      logic [WIDTH-1:0] cur, prv;
      cur = samp(n);
      prv = (n > 0) ? samp(n - 1) : '0;
      for (int b = 0; b < WIDTH; b++) begin
         if (m_mask[b]) begin
            if (cur[b] != m_value[b]) return 1'b0;
            if (m_edge[b] && (n == 0 || prv[b] == m_value[b])) return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   // Index of the trigger sample whose whole window fits in pat, or -1
   function automatic int find_trig();
      int nsamp;
      nsamp = (MAXE - 2) / (m_div + 1);
      for (int n = m_pre; n + DEPTH - m_pre <= nsamp; n++)
         if (trig_at(n)) return n;
      return -1;
   endfunction

   task automatic run_capture(input string name, input logic [WIDTH-1:0] mask,
                              input logic [WIDTH-1:0] value, input logic [WIDTH-1:0] edg,
                              input int pre, input int div);
      int t, d;
      m_mask = mask; m_value = value; m_edge = edg; m_pre = pre; m_div = div;
      t = find_trig();
      d = (t < 0) ? MAXE - 2 : 1 + (t + DEPTH - pre - 1) * (div + 1);
      trig_mask_i  = mask;
      trig_value_i = value;
      trig_edge_i  = edg;
      pre_i        = ADDR_W'(pre);
      div_i        = DIV_W'(div);
      arm_i        = 1'b1;
      data_i       = pat[0];
      @(posedge clk); #1;
      arm_i        = 1'b0;
      trig_mask_i  = WIDTH'($urandom);
      trig_value_i = WIDTH'($urandom);
      trig_edge_i  = WIDTH'($urandom);
      pre_i        = ADDR_W'($urandom);
      div_i        = DIV_W'($urandom);
      check({name, " state_after_arm"}, int'(state_o), (pre == 0) ? 2 : 1);
      data_i = pat[1];
      for (int j = 1; j <= d; j++) begin
         @(posedge clk); #1;
         if (j == d - 1) check({name, " done_early"}, int'(done_o), 0);
         data_i = pat[j + 1];
      end
      if (t < 0) begin
         check({name, " no_trigger_done"}, int'(done_o), 0);
      end else begin
         check({name, " done"}, int'(done_o), 1);
         check({name, " state_done"}, int'(state_o), 4);
         for (int a = 0; a < DEPTH; a++) begin
            rd_addr_i = ADDR_W'(a);
            @(posedge clk); #1;
            rb[a] = rd_data_o;
            check({name, " window"}, int'(rb[a]), int'(samp(t - pre + a)));
         end
      end
   endtask

   rd_vec_t rvec [5];
   ab_vec_t avec [9];

   initial begin
      rst = 1'b0; data_i = '0; arm_i = 1'b0; abort_i = 1'b0;
      trig_mask_i = '0; trig_value_i = '0; trig_edge_i = '0;
      pre_i = '0; div_i = '0; rd_addr_i = '0;

      // Reset held three clocks, arm pulsed during reset must be ignored
      arm_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset state", int'(state_o), 0);
      check("reset done", int'(done_o), 0);
      check("reset rd_data", int'(rd_data_o), 0);
      arm_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("idle after reset", int'(state_o), 0);

      // Level trigger on ramp data
      for (int j = 0; j < MAXE; j++) pat[j] = WIDTH'(12'h010 + j);
      run_capture("level", 12'hFFF, 12'h020, 12'h000, 4, 0);
      rvec[0] = '{4'd0,  12'h01C};
      rvec[1] = '{4'd4,  12'h020};
      rvec[2] = '{4'd15, 12'h02B};
      rvec[3] = '{4'd1,  12'h01D};
      rvec[4] = '{4'd10, 12'h026};
      for (int i = 0; i < 5; i++) begin
         rd_addr_i = rvec[i].addr;
         @(posedge clk); #1;
         check("level table", int'(rd_data_o), int'(rvec[i].exp));
      end

      // Rising edge of LAT: high at arm, falls, then rises at sample 30
      for (int j = 0; j < MAXE; j++) begin
         pat[j] = WIDTH'($urandom);
         pat[j][6] = (j <= 20 || j >= 31);
      end
      run_capture("lat edge", 12'h040, 12'h040, 12'h040, 3, 0);
      check("lat edge at pre", int'(rb[3][6]), 1);
      check("lat low before", int'(rb[2][6]), 0);
      check("lat sample", int'(rb[3]), int'(pat[31]));

      // Immediate trigger with no pre-trigger samples
      for (int j = 0; j < MAXE; j++) pat[j] = WIDTH'($urandom);
      run_capture("immediate", 12'h000, 12'h000, 12'h000, 0, 0);
      check("immediate addr0", int'(rb[0]), int'(pat[1]));

      // A match during PRE is ignored; the later one triggers
      for (int j = 0; j < MAXE; j++) begin
         pat[j] = WIDTH'($urandom);
         if (pat[j] == 12'hABC) pat[j] = 12'hABD;
      end
      pat[4]  = 12'hABC;
      pat[13] = 12'hABC;
      run_capture("pre ignore", 12'hFFF, 12'hABC, 12'h000, 8, 0);
      check("pre ignore trig", int'(rb[8]), 12'hABC);

      // Divider on ramp data
      for (int j = 0; j < MAXE; j++) pat[j] = WIDTH'(j);
      run_capture("divider", 12'h000, 12'h000, 12'h000, 5, 2);
      for (int a = 0; a < 4; a++)
         check("divider step", int'(rb[a + 1] - rb[a]), 3);

      // Randomized captures
      for (int it = 0; it < 8; it++) begin
         for (int j = 0; j < MAXE; j++) pat[j] = WIDTH'($urandom);
         run_capture("random", WIDTH'($urandom_range(0, 7)), WIDTH'($urandom),
                     WIDTH'($urandom), $urandom_range(0, 15), $urandom_range(0, 3));
      end

      // Abort / arm priority sequence; the trigger never fires on zero data
      data_i = '0; trig_mask_i = 12'hFFF; trig_value_i = 12'hFFF;
      trig_edge_i = '0; div_i = '0;
      avec[0] = '{1'b1, 1'b1, 0, 0};
      avec[1] = '{1'b1, 1'b0, 0, 2};
      avec[2] = '{1'b0, 1'b0, 0, 2};
      avec[3] = '{1'b1, 1'b0, 5, 1};
      avec[4] = '{1'b0, 1'b0, 0, 1};
      avec[5] = '{1'b0, 1'b1, 0, 0};
      avec[6] = '{1'b0, 1'b0, 0, 0};
      avec[7] = '{1'b1, 1'b0, 0, 2};
      avec[8] = '{1'b1, 1'b1, 0, 0};
      for (int i = 0; i < 9; i++) begin
         arm_i   = avec[i].arm;
         abort_i = avec[i].abort;
         pre_i   = ADDR_W'(avec[i].pre);
         @(posedge clk); #1;
         arm_i = 1'b0; abort_i = 1'b0;
         check("abort seq", int'(state_o), avec[i].exp_state);
      end

      // Reset asserted mid-capture returns to IDLE at once
      pre_i = 4'd3; arm_i = 1'b1;
      @(posedge clk); #1;
      arm_i = 1'b0;
      check("midrst pre", int'(state_o), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("midrst state", int'(state_o), 0);
      check("midrst done", int'(done_o), 0);
      @(posedge clk); #1;
      rst = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
